// File: rtl/residue_checker.sv
// residue_checker: recomputes the mod-31 residue of a retired result and flags mismatches against the predicted one
module residue_checker #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 7,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              chk_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [4:0]        resid_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              done_o,
    output logic              match_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [TAG_W-1:0]  cap_tag_o,
    output logic [DATA_W-1:0] cap_result_o,
    output logic [4:0]        cap_resid_o,
    input  logic              clr_i
);
    localparam int NCH = (DATA_W + 4) / 5;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, FOLD, CMP, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] res;
    logic [4:0]        rsd;
    logic [TAG_W-1:0]  tg;
    logic [4:0]        acc;
    logic [IW-1:0]     idx;
    logic              match;
    logic [NCH*5-1:0]  padded;
    logic [4:0]        chunk;
    logic [5:0]        s;

    function automatic logic [4:0] norm(input logic [4:0] v);
        return (v == 5'd31) ? 5'd0 : v;
    endfunction

    // current chunk and its 6-bit sum with the accumulator
    always_comb begin
        padded = (NCH*5)'(res);
        chunk  = padded[idx*5 +: 5];
        s      = {1'b0, acc} + {1'b0, chunk};
    end

    // request sequencing: accept, fold one chunk per cycle, compare, report
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            done_o  <= 1'b0;
            match_o <= 1'b0;
            tag_o   <= '0;
            acc     <= '0;
            idx     <= '0;
            res     <= '0;
            rsd     <= '0;
            tg      <= '0;
            match   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        res     <= result_i;
                        rsd     <= resid_i;
                        tg      <= tag_i;
                        acc     <= '0;
                        idx     <= '0;
                        match   <= 1'b1;
                        ready_o <= 1'b0;
                        state   <= chk_i ? FOLD : DONE;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                FOLD: begin
                    acc <= s[4:0] + {4'd0, s[5]};
                    idx <= idx + 1'b1;
                    if (idx == IW'(NCH - 1)) state <= CMP;
                end
                CMP: begin
                    match <= norm(acc) == norm(rsd);
                    state <= DONE;
                end
                DONE: begin
                    done_o  <= 1'b1;
                    match_o <= match;
                    tag_o   <= tg;
                    ready_o <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // sticky error, saturating count and first-mismatch capture; a mismatch outranks a coincident clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_o        <= 1'b0;
            err_cnt_o    <= '0;
            cap_tag_o    <= '0;
            cap_result_o <= '0;
            cap_resid_o  <= '0;
        end else if (done_o && !match_o) begin
            err_o     <= 1'b1;
            err_cnt_o <= clr_i ? CNT_W'(1) : (&err_cnt_o) ? err_cnt_o : err_cnt_o + 1'b1;
            if (!err_o || clr_i) begin
                cap_tag_o    <= tg;
                cap_result_o <= res;
                cap_resid_o  <= rsd;
            end
        end else if (clr_i) begin
            err_o        <= 1'b0;
            err_cnt_o    <= '0;
            cap_tag_o    <= '0;
            cap_result_o <= '0;
            cap_resid_o  <= '0;
        end
    end
endmodule

// File: tb/tb_residue_checker.sv
// tb_residue_checker: directed scoreboard bench for residue_checker, with a narrow-counter twin for saturation
module tb_residue_checker;
    logic        clk = 1'b0;
    logic        reset_n, valid_i, chk_i, clr_i;
    logic [31:0] result_i;
    logic [4:0]  resid_i;
    logic [6:0]  tag_i;
    logic        ready_o, done_o, match_o, err_o;
    logic [6:0]  tag_o, cap_tag_o;
    logic [15:0] err_cnt_o;
    logic [31:0] cap_result_o;
    logic [4:0]  cap_resid_o;
    logic        ready2, done2, match2, err2;
    logic [6:0]  tag2, cap_tag2;
    logic [1:0]  cnt2;
    logic [31:0] cap_result2;
    logic [4:0]  cap_resid2;

    typedef struct {logic [6:0] tag; logic m;} exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;
    logic        m_err;
    int          m_cnt, m_cnt2;
    logic [6:0]  m_ctag;
    logic [31:0] m_cres;
    logic [4:0]  m_crs;

    always #5 clk = ~clk;

    residue_checker dut (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o), .chk_i(chk_i),
        .result_i(result_i), .resid_i(resid_i), .tag_i(tag_i), .done_o(done_o), .match_o(match_o),
        .tag_o(tag_o), .err_o(err_o), .err_cnt_o(err_cnt_o), .cap_tag_o(cap_tag_o),
        .cap_result_o(cap_result_o), .cap_resid_o(cap_resid_o), .clr_i(clr_i)
    );

    residue_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready2), .chk_i(chk_i),
        .result_i(result_i), .resid_i(resid_i), .tag_i(tag_i), .done_o(done2), .match_o(match2),
        .tag_o(tag2), .err_o(err2), .err_cnt_o(cnt2), .cap_tag_o(cap_tag2),
        .cap_result_o(cap_result2), .cap_resid_o(cap_resid2), .clr_i(clr_i)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic model_match(input logic [31:0] r, input logic [4:0] rs);
        return (r % 32'd31) == ({27'd0, rs} % 32'd31);
    endfunction

    task automatic model_clear();
        m_err = 0; m_cnt = 0; m_cnt2 = 0; m_ctag = 0; m_cres = 0; m_crs = 0;
    endtask

    task automatic check_state(input string name);
        check({name, "_err"}, err_o, m_err);
        check({name, "_cnt"}, err_cnt_o, m_cnt);
        check({name, "_cnt2"}, cnt2, m_cnt2);
        check({name, "_ctag"}, cap_tag_o, m_ctag);
        check({name, "_cres"}, cap_result_o, m_cres);
        check({name, "_crs"}, cap_resid_o, m_crs);
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        model_clear();
        check_state("clr");
    endtask

    task automatic req(input logic c, input logic [31:0] r, input logic [4:0] rs, input logic [6:0] t,
                       input bit hold, input bit clr_done);
        int n;
        exp_t e;
        n = 0;
        while (!ready_o && n < 30) begin @(negedge clk); n++; end
        check("ready_wait", n < 30, 1);
        valid_i = 1'b1; chk_i = c; result_i = r; resid_i = rs; tag_i = t;
        sb.push_back('{t, c ? model_match(r, rs) : 1'b1});
        @(negedge clk);
        if (!hold) valid_i = 1'b0;
        n = 0;
        while (!done_o && n < 30) begin @(negedge clk); n++; end
        valid_i = 1'b0;
        check("latency", n, c ? 9 : 1);
        check("sb_depth", sb.size(), 1);
        e = '{7'd0, 1'b0};
        if (sb.size() > 0) e = sb.pop_front();
        check("tag_o", tag_o, e.tag);
        check("match_o", match_o, e.m);
        if (clr_done) clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        check("done_pulse", done_o, 0);
        if (!e.m) begin
            if (clr_done) begin
                m_cnt = 1; m_cnt2 = 1;
            end else begin
                m_cnt  = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 1;
                m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
            end
            if (!m_err || clr_done) begin m_ctag = t; m_cres = r; m_crs = rs; end
            m_err = 1;
        end
        check_state("req");
    endtask

    initial begin
        bit seen;
        reset_n = 1'b0; valid_i = 0; chk_i = 0; clr_i = 0; result_i = 0; resid_i = 0; tag_i = 0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_ready", ready_o, 1);
        check("rst_done", done_o, 0);
        check("rst_match", match_o, 0);
        check("rst_tag", tag_o, 0);
        check_state("rst");
        reset_n = 1'b1;
        @(negedge clk);
        req(1, 32'h0000_001F, 5'd0, 7'd1, 0, 0);
        req(1, 32'hFFFF_FFFF, 5'd3, 7'd2, 0, 0);
        req(1, 32'hFFFF_FFFF, 5'd4, 7'd3, 0, 0);
        pulse_clr();
        req(1, 32'd100, 5'd8, 7'd5, 0, 0);
        req(1, 32'd200, 5'd0, 7'd9, 0, 0);
        pulse_clr();
        req(1, 32'd1000, 5'd1, 7'd12, 0, 1);
        req(0, 32'h1234_5678, 5'd17, 7'd20, 1, 0);
        seen = 0;
        repeat (12) begin @(negedge clk); if (done_o) seen = 1; end
        check("no_extra_accept", seen, 0);
        req(1, 32'hDEAD_BEEF, 5'(32'hDEAD_BEEF % 32'd31), 7'd33, 0, 0);
        pulse_clr();
        for (int i = 1; i <= 5; i++) req(1, 32'd100 + i, 5'd30, 7'(40 + i), 0, 0);
        while (!ready_o) @(negedge clk);
        valid_i = 1'b1; chk_i = 1; result_i = 32'hFFFF_FFFF; resid_i = 5'd4; tag_i = 7'd77;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_clear();
        check("midrst_ready", ready_o, 1);
        check("midrst_done", done_o, 0);
        check("midrst_match", match_o, 0);
        check("midrst_tag", tag_o, 0);
        check_state("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (12) begin @(negedge clk); if (done_o) seen = 1; end
        check("midrst_no_done", seen, 0);
        req(1, 32'd31, 5'd31, 7'd99, 0, 0);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
